// File: rtl/jtpang_objdma.sv
// Sprite DMA engine: on a CPU go strobe, takes the Z80 bus and copies the
// object table from shared video RAM into the object line-buffer RAM.
// The read pipeline is one cen cycle deep: the byte addressed on one cen cycle
// is written on the next, so a lost bus discards exactly one in-flight read.
module jtpang_objdma #(
  parameter logic [11:0] SRC_BASE = 12'h000,
  parameter int unsigned LEN      = 512,
  parameter int unsigned OAW      = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           dma_go,
  output logic           busrq_n,
  input  logic           busak_n,
  output logic [11:0]    dma_addr,
  output logic           dma_rd,
  input  logic [7:0]     src_dout,
  output logic [OAW-1:0] obj_addr,
  output logic [7:0]     obj_din,
  output logic           obj_we,
  output logic           busy,
  output logic           done
);

  localparam int unsigned    CW   = 10;
  localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, COPY, FLUSH, REL} state_t;

  state_t          state;
  logic            go_q;
  logic            start_pend;
  logic            rd_valid;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   wr_cnt;
  logic            go_edge;

  assign go_edge = dma_go & ~go_q;

  // Go-strobe history; kept running through reset so a level held across
  // reset is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    go_q <= dma_go;
  end

  // Transfer sequencer with registered bus, read and write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      rd_valid   <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      busrq_n    <= 1'b1;
      dma_rd     <= 1'b0;
      dma_addr   <= SRC_BASE;
      obj_addr   <= '0;
      obj_din    <= 8'd0;
      obj_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      obj_we <= 1'b0;
      done   <= 1'b0;
      // An edge seen between cen cycles is held until the next one.
      if (go_edge && !busy) start_pend <= 1'b1;
      if (cen) begin
        start_pend <= 1'b0;
        case (state)
          IDLE: begin
            busrq_n <= 1'b1;
            if (start_pend || go_edge) begin
              state   <= REQ;
              busy    <= 1'b1;
              busrq_n <= 1'b0;
            end
          end
          REQ: begin
            busrq_n <= 1'b0;
            dma_rd  <= 1'b0;
            if (!busak_n) begin
              state    <= COPY;
              rd_cnt   <= wr_cnt;
              rd_valid <= 1'b0;
            end
          end
          COPY: begin
            if (busak_n) begin
              // Bus taken back: drop the pending read and retry from the
              // first byte not yet written.
              state    <= REQ;
              dma_rd   <= 1'b0;
              rd_cnt   <= wr_cnt;
              rd_valid <= 1'b0;
            end else begin
              if (rd_valid) begin
                obj_addr <= OAW'(wr_cnt);
                obj_din  <= src_dout;
                obj_we   <= 1'b1;
                wr_cnt   <= wr_cnt + CW'(1);
              end
              dma_rd   <= 1'b1;
              dma_addr <= SRC_BASE + 12'(rd_cnt);
              rd_cnt   <= rd_cnt + CW'(1);
              rd_valid <= 1'b1;
              if (rd_cnt == LAST) state <= FLUSH;
            end
          end
          FLUSH: begin
            dma_rd   <= 1'b0;
            obj_addr <= OAW'(wr_cnt);
            obj_din  <= src_dout;
            obj_we   <= 1'b1;
            wr_cnt   <= wr_cnt + CW'(1);
            rd_valid <= 1'b0;
            state    <= REL;
          end
          REL: begin
            busrq_n <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: a full-size instance (base 0, 512 bytes) under a
// random cen, and a small wrapping instance (base FFE, 4 bytes) at 1/8 cen.
// Expected buffers come straight from the source RAM contents.
module tb_jtpang_objdma;

  localparam int unsigned LEN_A = 512;
  localparam logic [11:0] SRC_A = 12'h000;
  localparam int unsigned LEN_B = 4;
  localparam logic [11:0] SRC_B = 12'hFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cen_a, cen_b;
  logic a_go, a_busak, a_busrq_n, a_dma_rd, a_obj_we, a_busy, a_done;
  logic [11:0] a_dma_addr;
  logic [7:0]  a_src, a_obj_din;
  logic [8:0]  a_obj_addr;
  logic b_go, b_busak, b_busrq_n, b_dma_rd, b_obj_we, b_busy, b_done;
  logic [11:0] b_dma_addr;
  logic [7:0]  b_src, b_obj_din;
  logic [8:0]  b_obj_addr;

  logic [7:0] ram_a [4096];
  logic [7:0] ram_b [4096];
  assign a_src = ram_a[a_dma_addr];
  assign b_src = ram_b[b_dma_addr];

  jtpang_objdma #(.SRC_BASE(SRC_A), .LEN(LEN_A), .OAW(9)) u_a (
    .clk(clk), .rst(rst), .cen(cen_a), .dma_go(a_go),
    .busrq_n(a_busrq_n), .busak_n(a_busak),
    .dma_addr(a_dma_addr), .dma_rd(a_dma_rd), .src_dout(a_src),
    .obj_addr(a_obj_addr), .obj_din(a_obj_din), .obj_we(a_obj_we),
    .busy(a_busy), .done(a_done)
  );

  jtpang_objdma #(.SRC_BASE(SRC_B), .LEN(LEN_B), .OAW(9)) u_b (
    .clk(clk), .rst(rst), .cen(cen_b), .dma_go(b_go),
    .busrq_n(b_busrq_n), .busak_n(b_busak),
    .dma_addr(b_dma_addr), .dma_rd(b_dma_rd), .src_dout(b_src),
    .obj_addr(b_obj_addr), .obj_din(b_obj_din), .obj_we(b_obj_we),
    .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observation state for instance A
  int cen_cnt_a;
  bit a_edge, a_busy_q, a_lost;
  int a_wr_total, a_done_cnt, a_busy_fall, a_we_lost, a_first_we_idx, a_done_idx;
  int a_wcount [512];
  logic [7:0] a_buf [512];
  int a_log [$];

  // Observation state for instance B
  int b_phase;
  bit b_we_prev;
  int b_wr_total, b_done_cnt, b_wide, b_unaligned;
  int b_wcount [512];
  logic [7:0] b_buf [512];
  logic [11:0] b_seq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, record what the rising edge produced,
  // then choose the cen values for the following rising edge.
  task automatic tick();
    @(negedge clk);
    a_edge = cen_a;
    if (cen_a) cen_cnt_a++;
    if (!rst) begin
      if (a_obj_we) begin
        if (a_wr_total == 0) a_first_we_idx = cen_cnt_a;
        a_wr_total++;
        a_wcount[a_obj_addr]++;
        a_buf[a_obj_addr] = a_obj_din;
        a_log.push_back(int'(a_obj_addr));
        if (a_lost) a_we_lost++;
      end
      if (a_done) begin a_done_cnt++; a_done_idx = cen_cnt_a; end
      if (a_busy_q && !a_busy) a_busy_fall++;
      if (b_obj_we) begin
        b_wr_total++;
        b_wcount[b_obj_addr]++;
        b_buf[b_obj_addr] = b_obj_din;
        if (!cen_b) b_unaligned++;
        if (b_we_prev) b_wide++;
      end
      b_we_prev = b_obj_we;
      if (b_done) b_done_cnt++;
      if (b_dma_rd && (b_seq.size() == 0 || b_seq[$] != b_dma_addr)) b_seq.push_back(b_dma_addr);
    end
    a_busy_q = a_busy;
    cen_a = ($urandom_range(0, 2) != 0);
    b_phase = (b_phase + 1) % 8;
    cen_b = (b_phase == 0);
  endtask

  task automatic cen_tick_a();
    do tick(); while (!a_edge);
  endtask

  task automatic clr_a();
    a_wr_total = 0; a_done_cnt = 0; a_busy_fall = 0; a_we_lost = 0;
    a_first_we_idx = -1; a_done_idx = -1; a_lost = 0;
    for (int i = 0; i < 512; i++) a_wcount[i] = 0;
    a_log.delete();
  endtask

  // Bytes in the object buffer that are missing, duplicated or wrong
  function automatic int a_mism();
    int m = 0;
    for (int i = 0; i < int'(LEN_A); i++)
      if (a_wcount[i] != 1 || a_buf[i] !== ram_a[12'(SRC_A + 12'(i))]) m++;
    return m;
  endfunction

  // Writes that did not arrive in strictly ascending order 0..LEN-1
  function automatic int a_order_bad();
    int m = 0;
    if (a_log.size() != int'(LEN_A)) return 1;
    for (int i = 0; i < int'(LEN_A); i++) if (a_log[i] != i) m++;
    return m;
  endfunction

  task automatic go_pulse_a();
    a_go = 1'b1; tick(); a_go = 1'b0;
  endtask

  task automatic wait_req_a(input string tag);
    int n = 0;
    while (a_busrq_n && n < 200) begin tick(); n++; end
    chk(tag, 32'(a_busrq_n), 32'd0);
  endtask

  task automatic wait_writes_a(input string tag, input int k);
    int n = 0;
    while (a_wr_total < k && n < 5000) begin tick(); n++; end
    chk(tag, 32'(a_wr_total >= k), 32'd1);
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (a_done_cnt == 0 && n < 10000) begin tick(); n++; end
    chk(tag, 32'(a_done_cnt > 0), 32'd1);
  endtask

  task automatic fill_rand_a();
    for (int i = 0; i < 4096; i++) ram_a[i] = 8'($urandom);
  endtask

  initial begin
    int grant_idx;
    int bad;
    int n;
    logic [11:0] exp_seq [4];
    rst = 1'b1; cen_a = 1'b0; cen_b = 1'b0; b_phase = 0;
    a_go = 1'b0; a_busak = 1'b1; b_go = 1'b0; b_busak = 1'b1;
    cen_cnt_a = 0; a_busy_q = 1'b0; b_we_prev = 1'b0;
    b_wr_total = 0; b_done_cnt = 0; b_wide = 0; b_unaligned = 0;
    for (int i = 0; i < 512; i++) b_wcount[i] = 0;
    for (int i = 0; i < 4096; i++) begin
      ram_a[i] = 8'(i) ^ 8'h5A;
      ram_b[i] = 8'($urandom);
    end
    clr_a();
    repeat (3) tick();

    // Reset state
    chk("rst_busrq_n", 32'(a_busrq_n), 32'd1);
    chk("rst_dma_rd",  32'(a_dma_rd),  32'd0);
    chk("rst_obj_we",  32'(a_obj_we),  32'd0);
    chk("rst_busy",    32'(a_busy),    32'd0);
    chk("rst_done",    32'(a_done),    32'd0);
    chk("rst_obj_addr",32'(a_obj_addr),32'd0);
    chk("rst_obj_din", 32'(a_obj_din), 32'd0);
    chk("rst_dma_addr_a", 32'(a_dma_addr), 32'(SRC_A));
    chk("rst_dma_addr_b", 32'(b_dma_addr), 32'(SRC_B));
    rst = 1'b0;
    repeat (4) tick();

    // Single go pulse, grant three cen cycles after the request
    clr_a();
    a_go = 1'b1; tick(); a_go = 1'b0;
    while (!a_edge) tick();
    chk("t1_busrq_first_cen", 32'(a_busrq_n), 32'd0);
    chk("t1_busy_up", 32'(a_busy), 32'd1);
    cen_tick_a(); cen_tick_a();
    chk("t1_no_wr_pregrant", 32'(a_wr_total), 32'd0);
    chk("t1_rd_pregrant", 32'(a_dma_rd), 32'd0);
    a_busak = 1'b0;
    grant_idx = cen_cnt_a + 1;
    wait_done_a("t1_done_timeout");
    a_busak = 1'b1;
    repeat (5) tick();
    chk("t1_writes", 32'(a_wr_total), 32'(LEN_A));
    chk("t1_data_mism", 32'(a_mism()), 32'd0);
    chk("t1_order", 32'(a_order_bad()), 32'd0);
    chk("t1_done_cnt", 32'(a_done_cnt), 32'd1);
    chk("t1_first_we_lat", 32'(a_first_we_idx - grant_idx), 32'd2);
    chk("t1_done_lat", 32'(a_done_idx - grant_idx), 32'(LEN_A + 2));
    chk("t1_busrq_rel", 32'(a_busrq_n), 32'd1);
    chk("t1_busy_end", 32'(a_busy), 32'd0);

    // Long go level, then a second edge mid-copy that must be ignored
    fill_rand_a(); clr_a();
    a_go = 1'b1; repeat (10) tick(); a_go = 1'b0;
    wait_req_a("t2_req");
    cen_tick_a();
    a_busak = 1'b0;
    wait_writes_a("t2_wr200", 200);
    a_go = 1'b1; repeat (3) tick(); a_go = 1'b0;
    wait_done_a("t2_done_timeout");
    a_busak = 1'b1;
    repeat (40) tick();
    chk("t2_writes", 32'(a_wr_total), 32'(LEN_A));
    chk("t2_data_mism", 32'(a_mism()), 32'd0);
    chk("t2_done_cnt", 32'(a_done_cnt), 32'd1);
    chk("t2_busy_fall", 32'(a_busy_fall), 32'd1);
    chk("t2_busrq_idle", 32'(a_busrq_n), 32'd1);

    // Bus lost for four cen cycles after the 100th write
    fill_rand_a(); clr_a();
    go_pulse_a();
    wait_req_a("t3_req");
    a_busak = 1'b0;
    wait_writes_a("t3_wr100", 100);
    a_busak = 1'b1; a_lost = 1'b1;
    repeat (4) cen_tick_a();
    chk("t3_busrq_held", 32'(a_busrq_n), 32'd0);
    chk("t3_rd_off", 32'(a_dma_rd), 32'd0);
    a_busak = 1'b0; a_lost = 1'b0;
    wait_done_a("t3_done_timeout");
    a_busak = 1'b1;
    repeat (5) tick();
    chk("t3_we_while_lost", 32'(a_we_lost), 32'd0);
    chk("t3_resume_addr", 32'(a_log.size() > 100 ? a_log[100] : -1), 32'd100);
    chk("t3_writes", 32'(a_wr_total), 32'(LEN_A));
    chk("t3_data_mism", 32'(a_mism()), 32'd0);
    chk("t3_order", 32'(a_order_bad()), 32'd0);

    // Grant withheld for 1000 cen cycles
    fill_rand_a(); clr_a();
    go_pulse_a();
    wait_req_a("t4_req");
    bad = 0;
    repeat (1000) begin
      cen_tick_a();
      if (a_busrq_n !== 1'b0 || a_dma_rd !== 1'b0 || a_busy !== 1'b1) bad++;
    end
    chk("t4_hold_bad", 32'(bad), 32'd0);
    chk("t4_no_writes", 32'(a_wr_total), 32'd0);
    a_busak = 1'b0;
    wait_done_a("t4_done_timeout");
    a_busak = 1'b1;
    repeat (5) tick();
    chk("t4_writes", 32'(a_wr_total), 32'(LEN_A));
    chk("t4_data_mism", 32'(a_mism()), 32'd0);

    // Reset pulse mid-copy, then a fresh transfer from the start
    fill_rand_a(); clr_a();
    go_pulse_a();
    wait_req_a("t5_req");
    a_busak = 1'b0;
    wait_writes_a("t5_wr50", 50);
    rst = 1'b1;
    tick();
    chk("t5_rst_busrq_n", 32'(a_busrq_n), 32'd1);
    chk("t5_rst_busy", 32'(a_busy), 32'd0);
    chk("t5_rst_obj_we", 32'(a_obj_we), 32'd0);
    chk("t5_rst_dma_rd", 32'(a_dma_rd), 32'd0);
    chk("t5_rst_obj_addr", 32'(a_obj_addr), 32'd0);
    rst = 1'b0; a_busak = 1'b1;
    repeat (6) tick();
    chk("t5_idle_after_rst", 32'(a_busrq_n), 32'd1);
    clr_a();
    go_pulse_a();
    wait_req_a("t5_req2");
    a_busak = 1'b0;
    wait_done_a("t5_done_timeout");
    a_busak = 1'b1;
    repeat (5) tick();
    chk("t5_restart_addr", 32'(a_log.size() > 0 ? a_log[0] : -1), 32'd0);
    chk("t5_writes", 32'(a_wr_total), 32'(LEN_A));
    chk("t5_data_mism", 32'(a_mism()), 32'd0);
    chk("t5_order", 32'(a_order_bad()), 32'd0);

    // Wrapping source addresses at 1/8 cen on the small instance
    b_seq.delete();
    b_go = 1'b1; tick(); b_go = 1'b0;
    n = 0;
    while (b_busrq_n && n < 100) begin tick(); n++; end
    chk("t6_req", 32'(b_busrq_n), 32'd0);
    b_busak = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 400) begin tick(); n++; end
    chk("t6_done", 32'(b_done_cnt), 32'd1);
    b_busak = 1'b1;
    repeat (20) tick();
    exp_seq[0] = 12'hFFE; exp_seq[1] = 12'hFFF; exp_seq[2] = 12'h000; exp_seq[3] = 12'h001;
    chk("t6_seq_len", 32'(b_seq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_addr%0d", i), 32'(b_seq.size() > i ? b_seq[i] : 12'hBAD), 32'(exp_seq[i]));
    chk("t6_writes", 32'(b_wr_total), 32'(LEN_B));
    bad = 0;
    for (int i = 0; i < int'(LEN_B); i++)
      if (b_wcount[i] != 1 || b_buf[i] !== ram_b[12'(SRC_B + 12'(i))]) bad++;
    chk("t6_data_mism", 32'(bad), 32'd0);
    chk("t6_we_wide", 32'(b_wide), 32'd0);
    chk("t6_we_unaligned", 32'(b_unaligned), 32'd0);
    chk("t6_busrq_rel", 32'(b_busrq_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
